// File: rtl/dnn_weight_sequencer_pkg.sv
// dnn_pkg: state encoding and lane-enable helper shared by dnn_weight_sequencer and row_masker.
package dnn_pkg;
  localparam int MAX_LANES = 32;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  function automatic logic [MAX_LANES-1:0] lane_mask(input int lnn, input int max);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int k = 0; k < MAX_LANES; k++) m[k] = (k < max) && (k >= max - lnn);
    return m;
  endfunction
endpackage

// File: rtl/dnn_weight_sequencer_if.sv
// dnn_weight_sequencer_if: upstream row stream plus DNN weight port; carries out_checksum when WEIGHT_CHECKSUM_EN is defined.
interface dnn_weight_sequencer_if #(
  parameter int NumLayers = 2,
  parameter int MaxNumNerves = 4,
  parameter int M_W_BitSize = 4
);
  logic start, in_valid, in_ready, out_busy, out_done;
  logic [MaxNumNerves*M_W_BitSize-1:0] in_weights, out_weights;
  logic [NumLayers-1:0] out_load_weights;
`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] out_checksum;
  modport master(output start, in_valid, in_weights,
                 input in_ready, out_weights, out_load_weights, out_busy, out_done, out_checksum);
  modport slave(input start, in_valid, in_weights,
                output in_ready, out_weights, out_load_weights, out_busy, out_done, out_checksum);
`else
  modport master(output start, in_valid, in_weights,
                 input in_ready, out_weights, out_load_weights, out_busy, out_done);
  modport slave(input start, in_valid, in_weights,
                output in_ready, out_weights, out_load_weights, out_busy, out_done);
`endif
endinterface

// File: rtl/dnn_weight_sequencer_row_masker.sv
// row_masker: zeroes the low lanes of a weight row that the selected layer does not use.
module row_masker import dnn_pkg::*; #(
  parameter int NumLayers = 2,
  parameter int MaxNumNerves = 4,
  parameter int M_W_BitSize = 4,
  parameter int LNN [NumLayers-1:0] = '{2, 4},
  parameter int LW = 1
) (
  input  logic [LW-1:0] layer,
  input  logic [MaxNumNerves*M_W_BitSize-1:0] row,
  output logic [MaxNumNerves*M_W_BitSize-1:0] masked
);
  logic [MaxNumNerves-1:0] en;
  assign en = MaxNumNerves'(lane_mask(LNN[layer], MaxNumNerves));
  for (genvar k = 0; k < MaxNumNerves; k++) begin : g_lane
    assign masked[k*M_W_BitSize +: M_W_BitSize] = en[k] ? row[k*M_W_BitSize +: M_W_BitSize] : '0;
  end
endmodule

// File: rtl/dnn_weight_sequencer.sv
// dnn_weight_sequencer: loads weight rows layer NumLayers-1 down to 0, strobing one-hot out_load_weights with masked rows.
// Defining WEIGHT_CHECKSUM_EN adds out_checksum, a running mod-2^16 sum of the unmasked lanes.
module dnn_weight_sequencer import dnn_pkg::*; #(
  parameter int NumLayers = 2,
  parameter int MaxNumNerves = 4,
  parameter int M_W_BitSize = 4,
  parameter int LNN [NumLayers-1:0] = '{2, 4},
  parameter int LIn [NumLayers-1:0] = '{4, 4}
) (
  input logic clk,
  input logic res_n,
  dnn_weight_sequencer_if.slave bus
);
  function automatic int max_lin();
    int m = 1;
    for (int l = 0; l < NumLayers; l++) m = LIn[l] > m ? LIn[l] : m;
    return m;
  endfunction
  localparam int LW = NumLayers > 1 ? $clog2(NumLayers) : 1;
  localparam int RW = max_lin() > 1 ? $clog2(max_lin()) : 1;
  localparam int DW = MaxNumNerves * M_W_BitSize;
  state_t state, nxt;
  logic [LW-1:0] layer;
  logic [RW-1:0] row;
  logic [DW-1:0] masked;
  logic accept, last_row, start_acc;
  assign accept = state == LOAD && bus.in_valid;
  assign last_row = row == RW'(LIn[layer] - 1);
  // the out_done cycle still blocks start, so a new load begins no earlier than the cycle after it
  assign start_acc = state == IDLE && bus.start && !bus.out_done;
  assign bus.in_ready = state == LOAD;
  assign bus.out_busy = state == LOAD;
  row_masker #(.NumLayers(NumLayers), .MaxNumNerves(MaxNumNerves), .M_W_BitSize(M_W_BitSize),
               .LNN(LNN), .LW(LW)) u_mask (.layer(layer), .row(bus.in_weights), .masked(masked));
  always_comb begin
    nxt = state == IDLE ? (start_acc ? LOAD : IDLE) :
          state == LOAD ? (accept && last_row && layer == '0 ? DONE : LOAD) : IDLE;
  end
  always_ff @(posedge clk) state <= !res_n ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (!res_n) begin
      layer <= '0;
      row <= '0;
      bus.out_weights <= '0;
      bus.out_load_weights <= '0;
      bus.out_done <= 1'b0;
    end else begin
      bus.out_done <= state == DONE;
      bus.out_load_weights <= accept ? NumLayers'(1) << layer : '0;
      if (accept) bus.out_weights <= masked;
      if (start_acc) begin
        layer <= LW'(NumLayers - 1);
        row <= '0;
      end else if (accept) begin
        row <= last_row ? '0 : row + 1'b1;
        if (last_row && layer != '0) layer <= layer - 1'b1;
      end
    end
  end
`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] lane_sum;
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < MaxNumNerves; k++) lane_sum = lane_sum + 16'(masked[k*M_W_BitSize +: M_W_BitSize]);
  end
  always_ff @(posedge clk)
    bus.out_checksum <= !res_n || start_acc ? '0 : accept ? bus.out_checksum + lane_sum : bus.out_checksum;
`endif
endmodule

// File: tb/tb_dnn_weight_sequencer.sv
// tb_dnn_weight_sequencer: vector table plus strobe scoreboard for dnn_weight_sequencer; checksum case under WEIGHT_CHECKSUM_EN.
module tb_dnn_weight_sequencer;
  typedef struct packed {logic v; logic [15:0] w; logic [1:0] ld; logic [15:0] ew;} vec_t;
  logic clk = 0, res_n = 0;
  int checks = 0, failures = 0, cyc = 0, last_strobe = -10, nstrobes = 0, ndone = 0, n, s;
  logic [17:0] sb[$];
  vec_t tbl[16];
  dnn_weight_sequencer_if #(.NumLayers(2), .MaxNumNerves(4), .M_W_BitSize(4)) bus();
  dnn_weight_sequencer dut (.clk(clk), .res_n(res_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (bus.out_load_weights != '0) begin
      nstrobes++;
      last_strobe = cyc;
      if (sb.size() == 0) chk("unexpected_strobe", {bus.out_load_weights, bus.out_weights}, 0);
      else chk("strobe", {bus.out_load_weights, bus.out_weights}, sb.pop_front());
    end
    if (bus.out_done) begin
      ndone++;
      chk("done_after_last_strobe", cyc, last_strobe + 1);
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic do_start();
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask
  task automatic beat(input logic v, input logic [15:0] w, input logic [17:0] e);
    bus.in_valid = v;
    bus.in_weights = w;
    chk("in_ready_load", bus.in_ready, 1);
    chk("busy_load", bus.out_busy, 1);
    if (v) sb.push_back(e);
    tick();
  endtask
  task automatic wait_done(input int n0);
    int k = 0;
    bus.in_valid = 0;
    while (ndone == n0 && k < 20) begin
      tick();
      k++;
    end
    chk("done_seen", ndone, n0 + 1);
    repeat (3) tick();
    chk("done_single", ndone, n0 + 1);
    chk("queue_drained", sb.size(), 0);
    chk("idle_busy", bus.out_busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 0;
    bus.in_valid = 0;
    bus.in_weights = '0;
    tbl = '{{1'b0, 16'hDEAD, 2'b00, 16'h0000}, {1'b1, 16'h4321, 2'b10, 16'h4300},
            {1'b0, 16'hBEEF, 2'b00, 16'h0000}, {1'b1, 16'hFFFF, 2'b10, 16'hFF00},
            {1'b0, 16'h1234, 2'b00, 16'h0000}, {1'b1, 16'h00AB, 2'b10, 16'h0000},
            {1'b0, 16'hFFFF, 2'b00, 16'h0000}, {1'b1, 16'h12F0, 2'b10, 16'h1200},
            {1'b0, 16'h5555, 2'b00, 16'h0000}, {1'b1, 16'h4321, 2'b01, 16'h4321},
            {1'b0, 16'hAAAA, 2'b00, 16'h0000}, {1'b1, 16'hFFFF, 2'b01, 16'hFFFF},
            {1'b0, 16'h0F0F, 2'b00, 16'h0000}, {1'b1, 16'h00AB, 2'b01, 16'h00AB},
            {1'b0, 16'h9999, 2'b00, 16'h0000}, {1'b1, 16'hA5C3, 2'b01, 16'hA5C3}};
    repeat (3) tick();
    chk("rst_weights", bus.out_weights, 0);
    chk("rst_load", bus.out_load_weights, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", bus.out_busy, 0);
    chk("rst_done", bus.out_done, 0);
    res_n = 1;
    tick();
    bus.in_valid = 1;
    bus.in_weights = 16'hFFFF;
    repeat (3) begin
      tick();
      chk("in_ready_idle", bus.in_ready, 0);
    end
    chk("idle_no_strobe", nstrobes, 0);
    bus.in_valid = 0;
    n = ndone; s = nstrobes;
    do_start();
    for (int i = 0; i < 8; i++) beat(1, 16'h4321, i < 4 ? {2'b10, 16'h4300} : {2'b01, 16'h4321});
    wait_done(n);
    chk("strobes_b2b", nstrobes - s, 8);
    n = ndone; s = nstrobes;
    do_start();
    foreach (tbl[i]) beat(tbl[i].v, tbl[i].w, {tbl[i].ld, tbl[i].ew});
    wait_done(n);
    chk("strobes_bubble", nstrobes - s, 8);
    do_start();
    for (int i = 0; i < 3; i++) beat(1, tbl[2*i+1].w, {tbl[2*i+1].ld, tbl[2*i+1].ew});
    res_n = 0;
    bus.in_valid = 1;
    tick();
    chk("midrst_load", bus.out_load_weights, 0);
    chk("midrst_weights", bus.out_weights, 0);
    chk("midrst_ready", bus.in_ready, 0);
    chk("midrst_busy", bus.out_busy, 0);
    tick();
    res_n = 1;
    bus.in_valid = 0;
    tick();
    chk("queue_after_reset", sb.size(), 0);
    n = ndone; s = nstrobes;
    do_start();
    foreach (tbl[i]) beat(tbl[i].v, tbl[i].w, {tbl[i].ld, tbl[i].ew});
    wait_done(n);
    chk("strobes_after_reset", nstrobes - s, 8);
    n = ndone; s = nstrobes;
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.start = (i == 2 || i == 5);
      beat(1, 16'h4321, i < 4 ? {2'b10, 16'h4300} : {2'b01, 16'h4321});
    end
    bus.in_valid = 0;
    bus.start = 1;
    tick();
    tick();
    bus.start = 0;
    wait_done(n);
    chk("strobes_start_ignored", nstrobes - s, 8);
    chk("no_restart_ready", bus.in_ready, 0);
`ifdef WEIGHT_CHECKSUM_EN
    n = ndone;
    do_start();
    for (int i = 0; i < 8; i++) beat(1, 16'hFFFF, i < 4 ? {2'b10, 16'hFF00} : {2'b01, 16'hFFFF});
    wait_done(n);
    chk("checksum", bus.out_checksum, 360);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dnn_weight_sequencer.md
# dnn_weight_sequencer

Parametrised weight-load sequencer between an upstream weight stream and the `top_v2` DNN weight port. It accepts one weight row per handshake and routes each row to the correct layer by driving a one-hot `out_load_weights`. Lanes that a layer does not use are zero-masked. It walks every layer's row count in a fixed order and then signals completion. It replaces per-layer hand sequencing of `in_weights`/`in_load_weights` and generalises to any layer count, nerve count and row count.

## Interface
- `NumLayers`, 2, number of DNN layers.
- `MaxNumNerves`, 4, lanes per weight row.
- `M_W_BitSize`, 4, bits per weight.
- `LNN`, '{2, 4}, integer array [NumLayers-1:0]: nerves in layer l, each ≤ MaxNumNerves.
- `LIn`, '{4, 4}, integer array [NumLayers-1:0]: rows (inputs) for layer l, each ≥ 1.
- `clk` in 1: clock, rising edge.
- `res_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a load sequence; sampled only in IDLE.
- `in_valid` in 1: upstream row valid.
- `in_ready` out 1: sequencer accepts a row this cycle.
- `in_weights` in MaxNumNerves*M_W_BitSize: packed row, lane k = bits [k*M_W_BitSize +: M_W_BitSize].
- `out_weights` out MaxNumNerves*M_W_BitSize: masked row to the DNN.
- `out_load_weights` out NumLayers: one-hot layer strobe for `out_weights`.
- `out_busy` out 1: high in LOAD.
- `out_done` out 1: one-cycle pulse after the final row has been issued.

## Operation
- States: IDLE, LOAD, DONE.
- IDLE → LOAD on `start`. Layer index is set to NumLayers-1 and the row counter to 0.
- LOAD transitions:
  - `in_ready` = 1. A beat is accepted when `in_valid && in_ready`.
  - For each accepted beat, register `out_weights` = `in_weights` with lanes [MaxNumNerves-LNN[l]-1:0] forced to 0; lanes [MaxNumNerves-1 : MaxNumNerves-LNN[l]] pass unchanged.
  - For each accepted beat, register `out_load_weights` = 1 << l.
  - The row counter increments per beat. When it reaches LIn[l]-1, the counter clears and l decrements.
  - The beat for row LIn[0]-1 of layer 0 moves the FSM to DONE.
- Load order is layer NumLayers-1 first, down to layer 0. Within a layer, row 0 is first.
- DONE: `out_done` = 1 for exactly one cycle, then IDLE.
- `in_ready` = 0 in IDLE and DONE.
- No downstream backpressure: the DNN consumes every strobed beat.
- `start` while in LOAD or DONE is ignored.
- A cycle with `in_valid` = 0 in LOAD drives `out_load_weights` = 0. `out_weights` holds its last value, and the counters hold.
- Counters are clog2(max LIn) bits and clog2(NumLayers) bits wide, with no wrap beyond the programmed counts.

## Timing
- Latency is 1 cycle from accept edge to `out_weights`/`out_load_weights` valid. All outputs are registered.
- Throughput is one row per cycle.
- `out_done` asserts the cycle after the final row's strobe.
- The earliest next `start` is accepted the cycle after `out_done`.
- Reset values: `out_weights` = 0, `out_load_weights` = 0, `in_ready` = 0, `out_busy` = 0, `out_done` = 0, state IDLE, all counters 0.
- Reset mid-LOAD abandons the partial load. No strobe is issued on the reset cycle or after it.
- `res_n` low on the same edge as `start` means reset wins.

## Configuration
- `WEIGHT_CHECKSUM_EN` defined:
  - Adds output `out_checksum` [15:0], the sum mod 2^16 of all unmasked lanes of accepted beats, as unsigned.
  - The sum is cleared on `start` acceptance and valid from `out_done`.
  - It is held until the next `start`.
  - Reset value 0.
- Undefined: no port and no adder logic.

## Structure
- Package `dnn_pkg`: state enum (IDLE/LOAD/DONE) and a `lane_mask(lnn, max)` constant function returning a MaxNumNerves-bit lane-enable vector.
- Sub-module `row_masker`: combinational lane zeroing from the layer index, instantiated once.

## Test plan
- Defaults, `start`, then 8 back-to-back rows 0x4321: 4 strobes `out_load_weights` = 2'b10 with `out_weights` = 0x4300, then 4 strobes 2'b01 with 0x4321, then `out_done` on the cycle after the 8th strobe.
- Same sequence with `in_valid` low on alternate cycles: strobes only on beat cycles, 8 strobes total, `in_ready` stays 1 throughout LOAD.
- Reset after 3 beats: outputs return to 0. A fresh `start` with 8 rows produces all 8 strobes from layer 1, row 0.
- `start` pulsed during LOAD and in the DONE cycle: no restart, exactly 8 strobes, one `out_done`.
- `in_valid` high in IDLE: `in_ready` = 0, no strobes.
- With `WEIGHT_CHECKSUM_EN`, 8 rows of 0xFFFF: `out_checksum` = 4·2·15 + 4·4·15 = 360 (0x0168).
